// File: rtl/mean_update.sv
// -----------------------------------------------------------------------------
// mean_update
//   Recomputes the T cluster means (mean = sum / count) at the end of a k-means
//   pass. On a start pulse all inputs are snapshotted; the clusters are then
//   processed one at a time with three shared-divisor restoring dividers
//   (R, G, B), one quotient bit per cycle. Results land in a shadow set that is
//   published to meanOut / changed_mask in a single cycle, so downstream logic
//   never sees a partially updated set.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   start         1-cycle pulse: snapshot inputs and begin an update
//   accumolator   per-cluster sums, slot i = {R_sum, G_sum, B_sum}
//   counters      per-cluster pixel counts, slot i = [i*CNT_W +: CNT_W]
//   enabled       bit i set: cluster i is active
//   meanIn        current means, slot i = [i*24 +: 24] = {R8, G8, B8}
//   meanOut       updated means, same layout as meanIn
//   busy          high from the cycle after start until the done cycle
//   done          1-cycle pulse when meanOut / changed_mask / changed are valid
//   changed_mask  bit i set: mean i differs from its snapshot value
//   changed       OR of changed_mask
// -----------------------------------------------------------------------------
module mean_update #(
    parameter int T     = 16,
    parameter int SUM_W = 24,
    parameter int CNT_W = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3*SUM_W*T-1:0]   accumolator,
    input  logic [CNT_W*T-1:0]     counters,
    input  logic [15:0]            enabled,
    input  logic [16*24-1:0]       meanIn,
    output logic [16*24-1:0]       meanOut,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            changed_mask,
    output logic                   changed
);

    localparam int ACC_W  = 3 * SUM_W;
    localparam int ITER_W = $clog2(SUM_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state;
    logic [3:0]          idx;
    logic [ITER_W-1:0]   iter;
    logic                skip;

    // Snapshot of the inputs taken at start
    logic [ACC_W*T-1:0]  snap_acc;
    logic [CNT_W*T-1:0]  snap_cnt;
    logic [15:0]         snap_en;
    logic [16*24-1:0]    snap_mean;

    // Divider state: channel 0 = R, 1 = G, 2 = B; quo starts as the dividend
    logic [SUM_W:0]      rem     [3];
    logic [SUM_W-1:0]    quo     [3];
    logic [SUM_W-1:0]    divisor;

    // Results accumulate here and are published only in DONE
    logic [T*24-1:0]     shadow_mean;
    logic [T-1:0]        shadow_mask;

    logic [ACC_W-1:0]    slot_sum;
    logic [CNT_W-1:0]    slot_cnt;
    logic [23:0]         old_mean;
    logic                load_skip;
    logic [SUM_W:0]      rem_sh  [3];
    logic [2:0]          ge;
    logic [23:0]         new_mean;
    logic [16*24-1:0]    next_mean_out;
    logic [15:0]         next_mask;
    logic                accept;

    function automatic logic [7:0] sat8(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:8]) ? 8'hFF : q[7:0];
    endfunction

    assign accept = (state == S_IDLE) && start && !busy;

    // NOTE: every signal assigned in this block gets a value on every path
    // (defaults first), otherwise synthesis infers latches.
    always_comb begin
        slot_sum  = snap_acc[idx*ACC_W +: ACC_W];
        slot_cnt  = snap_cnt[idx*CNT_W +: CNT_W];
        old_mean  = snap_mean[idx*24 +: 24];
        load_skip = !snap_en[idx] || (slot_cnt == '0);

        // Restoring step: shift in the next dividend bit, subtract if it fits
        for (int c = 0; c < 3; c++) begin
            rem_sh[c] = {rem[c][SUM_W-1:0], quo[c][SUM_W-1]};
            ge[c]     = (rem_sh[c] >= {1'b0, divisor});
        end

        new_mean = skip ? old_mean : {sat8(quo[0]), sat8(quo[1]), sat8(quo[2])};

        // Slots beyond T pass the snapshot means through with a clear mask bit
        next_mean_out            = snap_mean;
        next_mean_out[T*24-1:0]  = shadow_mean;
        next_mask                = '0;
        next_mask[T-1:0]         = shadow_mask;
    end

    // NOTE: snapshot, divider and shadow registers carry no reset; each is
    // written before it is read in every update, so resetting them would only
    // add reset fan-out to wide datapath storage.
    always_ff @(posedge clk) begin
        if (accept) begin
            snap_acc  <= accumolator;
            snap_cnt  <= counters;
            snap_en   <= enabled;
            snap_mean <= meanIn;
        end

        if (state == S_LOAD) begin
            divisor <= {{(SUM_W-CNT_W){1'b0}}, slot_cnt};
            for (int c = 0; c < 3; c++) begin
                rem[c] <= '0;
                quo[c] <= slot_sum[(2-c)*SUM_W +: SUM_W];
            end
        end else if (state == S_DIV) begin
            for (int c = 0; c < 3; c++) begin
                rem[c] <= ge[c] ? (rem_sh[c] - {1'b0, divisor}) : rem_sh[c];
                quo[c] <= {quo[c][SUM_W-2:0], ge[c]};
            end
        end

        if (state == S_WRITE) begin
            shadow_mean[idx*24 +: 24] <= new_mean;
            shadow_mask[idx]          <= (new_mean != old_mean);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            iter         <= '0;
            skip         <= 1'b0;
            meanOut      <= '0;
            changed_mask <= '0;
            changed      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // busy/done from the DONE cycle are retired here, one
                    // cycle later, so busy covers the done cycle as well
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (accept) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    skip  <= load_skip;
                    iter  <= '0;
                    state <= load_skip ? S_WRITE : S_DIV;
                end
                S_DIV: begin
                    iter <= iter + 1'b1;
                    if (iter == ITER_W'(SUM_W - 1))
                        state <= S_WRITE;
                end
                S_WRITE: begin
                    if (idx == 4'(T - 1)) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    meanOut      <= next_mean_out;
                    changed_mask <= next_mask;
                    changed      <= |next_mask;
                    done         <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mean_update.sv
// -----------------------------------------------------------------------------
// tb_mean_update
//   Directed and randomized checks of mean_update against a plain-arithmetic
//   reference (integer divide, clamp to 255, compare with the old mean).
//   Cycle numbering: the cycle in which start is high is cycle 0; outputs are
//   sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mean_update;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [1151:0]  acc = '0;
    logic [191:0]   cnt = '0;
    logic [15:0]    en = '0;
    logic [383:0]   mean_in = '0;
    logic [383:0]   mean_out;
    logic           busy;
    logic           done;
    logic [15:0]    changed_mask;
    logic           changed;

    int tests = 0;
    int fails = 0;

    logic [383:0]   exp_mean;
    logic [15:0]    exp_mask;
    int             exp_cycle;
    int             done_cycle;

    always #5 clk = ~clk;

    mean_update #(.T(16), .SUM_W(24), .CNT_W(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .accumolator  (acc),
        .counters     (cnt),
        .enabled      (en),
        .meanIn       (mean_in),
        .meanOut      (mean_out),
        .busy         (busy),
        .done         (done),
        .changed_mask (changed_mask),
        .changed      (changed)
    );

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: mean = floor(sum/count) clamped to 255; skipped clusters keep
    // the old mean; done cycle = 1 + sum of per-cluster latencies + 1.
    task automatic compute_expected();
        int s, c, q;
        logic [23:0] old_m, new_m;
        exp_cycle = 2;
        exp_mask  = '0;
        for (int i = 0; i < 16; i++) begin
            c     = int'(cnt[i*12 +: 12]);
            old_m = mean_in[i*24 +: 24];
            if (en[i] && c != 0) begin
                exp_cycle += 26;
                for (int ch = 0; ch < 3; ch++) begin
                    s = int'(acc[i*72 + (2-ch)*24 +: 24]);
                    q = s / c;
                    if (q > 255) q = 255;
                    new_m[(2-ch)*8 +: 8] = q[7:0];
                end
            end else begin
                exp_cycle += 2;
                new_m = old_m;
            end
            exp_mean[i*24 +: 24] = new_m;
            exp_mask[i]          = (new_m != old_m);
        end
    endtask

    task automatic randomize_inputs();
        int c;
        for (int i = 0; i < 16; i++) begin
            c = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 4095));
            cnt[i*12 +: 12] = c[11:0];
            for (int ch = 0; ch < 3; ch++) begin
                int s;
                if (c == 0)
                    s = int'($urandom % 24'hFFFFFF);
                else
                    s = c * int'($urandom_range(0, 300)) + int'($urandom % c);
                acc[i*72 + ch*24 +: 24] = s[23:0];
            end
        end
        en      = 16'($urandom);
        for (int i = 0; i < 12; i++) mean_in[i*32 +: 32] = $urandom;
    endtask

    // Phase on entry and exit: 1 time unit after a rising edge.
    // Inputs are scrambled in cycle 2 so results must come from the snapshot.
    task automatic run(input string name, input int second_start);
        int cyc;
        int busy_bad;
        busy_bad   = 0;
        done_cycle = -1;
        check({name, " idle busy"}, 384'(busy), 384'(0));
        start = 1'b1;
        cyc   = 0;
        while (cyc < 2000 && done_cycle < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == 2) randomize_inputs();
            if (second_start > 0 && cyc == second_start)     start = 1'b1;
            if (second_start > 0 && cyc == second_start + 1) start = 1'b0;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) done_cycle = cyc;
        end
        check({name, " done cycle"}, 384'(done_cycle), 384'(exp_cycle));
        check({name, " busy held"}, 384'(busy_bad), 384'(0));
        check({name, " meanOut"}, mean_out, exp_mean);
        check({name, " mask"}, 384'(changed_mask), 384'(exp_mask));
        check({name, " changed"}, 384'(changed), 384'(|exp_mask));
        @(posedge clk);
        #1;
        check({name, " done pulse"}, 384'(done), 384'(0));
        check({name, " busy drop"}, 384'(busy), 384'(0));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset meanOut", mean_out, '0);
        check("reset busy", 384'(busy), 384'(0));
        check("reset done", 384'(done), 384'(0));
        check("reset mask", 384'(changed_mask), 384'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: single enabled cluster, exact quotients
        randomize_inputs();
        en = 16'h0001;
        acc[71:0] = {24'd1000, 24'd500, 24'd255};
        cnt[11:0] = 12'd10;
        compute_expected();
        run("t1", 0);
        check("t1 slot0", 384'(mean_out[23:0]), 384'(24'h643219));
        check("t1 latency", 384'(done_cycle), 384'(58));

        // 2: enabled but zero count keeps the old mean
        randomize_inputs();
        en = 16'h0001;
        cnt[11:0] = 12'd0;
        mean_in[23:0] = 24'hABCDEF;
        compute_expected();
        run("t2", 0);
        check("t2 slot0", 384'(mean_out[23:0]), 384'(24'hABCDEF));
        check("t2 mask0", 384'(changed_mask[0]), 384'(0));

        // 3: saturating red channel
        randomize_inputs();
        en = 16'h0008;
        acc[3*72 +: 72] = {24'd5000, 24'd20, 24'd7};
        cnt[3*12 +: 12] = 12'd1;
        mean_in[3*24 +: 24] = 24'h000000;
        compute_expected();
        run("t3", 0);
        check("t3 slot3", 384'(mean_out[3*24 +: 24]), 384'(24'hFF1407));
        check("t3 mask3", 384'(changed_mask[3]), 384'(1));

        // 4: all enabled, every mean 0x10, full-length run
        en = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            int c;
            c = int'($urandom_range(1, 4095));
            cnt[i*12 +: 12] = c[11:0];
            for (int ch = 0; ch < 3; ch++) acc[i*72 + ch*24 +: 24] = 24'(16 * c);
        end
        compute_expected();
        run("t4", 0);
        check("t4 all 0x10", mean_out, {16{24'h101010}});
        check("t4 latency", 384'(done_cycle), 384'(418));

        // 5: second start mid-run is ignored
        en = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            int c;
            c = int'($urandom_range(1, 4095));
            cnt[i*12 +: 12] = c[11:0];
            for (int ch = 0; ch < 3; ch++)
                acc[i*72 + ch*24 +: 24] = 24'(c * (i * 3 + ch + 1) + (c - 1));
        end
        compute_expected();
        run("t5", 100);
        check("t5 latency", 384'(done_cycle), 384'(418));

        // 6: reset mid-run aborts with no done pulse
        begin
            int done_seen;
            done_seen = 0;
            randomize_inputs();
            en = 16'hFFFF;
            start = 1'b1;
            for (int cyc = 1; cyc <= 60; cyc++) begin
                @(posedge clk);
                #1;
                if (cyc == 1) start = 1'b0;
                if (cyc == 50) reset = 1'b0;
                if (done === 1'b1) done_seen++;
            end
            check("t6 no done", 384'(done_seen), 384'(0));
            check("t6 meanOut", mean_out, '0);
            check("t6 busy", 384'(busy), 384'(0));
            check("t6 mask", 384'(changed_mask), 384'(0));
            reset = 1'b1;
            @(posedge clk);
            #1;
        end
        randomize_inputs();
        compute_expected();
        run("t6 restart", 0);

        // Randomized passes
        for (int n = 0; n < 6; n++) begin
            randomize_inputs();
            compute_expected();
            run($sformatf("rand%0d", n), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
